perf_counter_poller: RTL and testbench

Management-domain initiator that sweeps the per-port performance counter register space over the 16-bit-address / 48-bit-data management read bus and caches the results. It issues `rd_en`/`rd_addr` requests toward a port's performance readout block, waits for the cross-domain `rd_valid` response with a timeout, and stores each value in a local register cache. The management CPU reads the cache with single-cycle latency and never stalls on slow or dead PHY/MAC clock domains.

---
 rtl/perf_counter_poller.sv | 190 +++++++++++++++++++
 tb/tb_perf_counter_poller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_poller.sv
// rtl/perf_counter_poller.sv - management-domain performance counter sweeper with local read cache
module perf_counter_poller #(
   parameter bit          HAS_SGMII      = 1'b0,
   parameter int unsigned POLL_INTERVAL  = 125000,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk_mgmt,
   input  logic        rst_mgmt,
   input  logic        enable,
   input  logic        snapshot_req,
   output logic        rd_en,
   output logic [15:0] rd_addr,
   input  logic        rd_valid,
   input  logic [47:0] rd_data,
   input  logic        cache_rd_en,
   input  logic [3:0]  cache_rd_idx,
   output logic        cache_rd_valid,
   output logic [47:0] cache_rd_data,
   output logic        cache_rd_stale,
   output logic        sweep_done,
   output logic [31:0] sweep_count,
   output logic [15:0] timeout_count,
   output logic        busy
);

   localparam int unsigned NUM_REGS = HAS_SGMII ? 9 : 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  idx_q;
   logic [31:0] wait_cnt;
   logic [31:0] interval_cnt;
   logic        snap_pend;
   logic        start;
   logic        issue;
   logic        accept;
   logic        expire;
   logic        last_idx;
   logic [47:0] cache [16];
   logic [15:0] stale;

   // Cache index to readout-block register address.
   function automatic logic [15:0] idx_to_addr(input logic [3:0] i);
      logic [15:0] a;
      case (i)
         4'd0:    a = 16'h1000;
         4'd1:    a = 16'h1001;
         4'd2:    a = 16'h1180;
         4'd3:    a = 16'h1181;
         4'd4:    a = 16'h1182;
         4'd5:    a = 16'h0000;
         4'd6:    a = 16'h0001;
         4'd7:    a = 16'h0002;
         4'd8:    a = 16'h0003;
         default: a = 16'h0000;
      endcase
      return a;
   endfunction

   assign last_idx = (idx_q == 4'(NUM_REGS - 1));
   assign busy     = (state_q != IDLE);

   // Next-state logic; a response in the last window cycle takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      issue   = 1'b0;
      accept  = 1'b0;
      expire  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && (interval_cnt == 32'd0 || snap_pend || snapshot_req)) begin
               start   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            issue   = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (rd_valid) begin
               accept = 1'b1;
            end else if (wait_cnt == TIMEOUT_CYCLES) begin
               expire = 1'b1;
            end
            if (accept || expire) begin
               state_d = last_idx ? IDLE : ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state, request outputs, interval/wait timers and sweep statistics.
   always_ff @(posedge clk_mgmt) begin
      if (rst_mgmt) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         wait_cnt      <= '0;
         interval_cnt  <= '0;
         snap_pend     <= 1'b0;
         rd_en         <= 1'b0;
         rd_addr       <= '0;
         sweep_done    <= 1'b0;
         sweep_count   <= '0;
         timeout_count <= '0;
      end else begin
         state_q    <= state_d;
         rd_en      <= issue;
         rd_addr    <= issue ? idx_to_addr(idx_q) : 16'h0000;
         sweep_done <= 1'b0;

         if (start) begin
            snap_pend <= 1'b0;
            idx_q     <= '0;
         end else if (snapshot_req) begin
            snap_pend <= 1'b1;
         end

         if (state_q == IDLE && interval_cnt != 32'd0) begin
            interval_cnt <= interval_cnt - 32'd1;
         end

         if (issue) begin
            wait_cnt <= '0;
         end else if (state_q == WAIT) begin
            wait_cnt <= wait_cnt + 32'd1;
         end

         if (expire && timeout_count != 16'hFFFF) begin
            timeout_count <= timeout_count + 16'd1;
         end

         if (accept || expire) begin
            if (last_idx) begin
               sweep_done   <= 1'b1;
               sweep_count  <= sweep_count + 32'd1;
               interval_cnt <= POLL_INTERVAL;
            end else begin
               idx_q <= idx_q + 4'd1;
            end
         end
      end
   end

   // Cache storage: responses refresh data, timeouts only mark the entry stale.
   always_ff @(posedge clk_mgmt) begin
      if (rst_mgmt) begin
         stale <= '1;
         for (int i = 0; i < 16; i++) begin
            cache[i] <= '0;
         end
      end else begin
         if (accept) begin
            cache[idx_q] <= rd_data;
            stale[idx_q] <= 1'b0;
         end else if (expire) begin
            stale[idx_q] <= 1'b1;
         end
      end
   end

   // Host read port; registered so a same-cycle write returns the previous value.
   always_ff @(posedge clk_mgmt) begin
      if (rst_mgmt) begin
         cache_rd_valid <= 1'b0;
         cache_rd_data  <= '0;
         cache_rd_stale <= 1'b0;
      end else begin
         cache_rd_valid <= cache_rd_en;
         if (cache_rd_en) begin
            if (cache_rd_idx < 4'(NUM_REGS)) begin
               cache_rd_data  <= cache[cache_rd_idx];
               cache_rd_stale <= stale[cache_rd_idx];
            end else begin
               cache_rd_data  <= '0;
               cache_rd_stale <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_perf_counter_poller.sv
// tb/tb_perf_counter_poller.sv - directed bench for perf_counter_poller
module tb_perf_counter_poller;

   logic        clk = 1'b0;
   logic        rst;
   logic        en0, en1, snap0, snap1;
   logic        rd_valid;
   logic [47:0] rd_data;
   logic        cache_rd_en;
   logic [3:0]  cache_rd_idx;

   logic        rd_en0, rd_en1;
   logic [15:0] rd_addr0, rd_addr1;
   logic        crv0, crv1, crs0, crs1;
   logic [47:0] crd0, crd1;
   logic        done0, done1, busy0, busy1;
   logic [31:0] scnt0, scnt1;
   logic [15:0] tcnt0, tcnt1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int          lat = 5;
   logic [15:0] silent_addr = 16'hFFFF;
   bit          late_en = 1'b0;
   bit          exact_en = 1'b0;
   logic [7:0]  tag = 8'h01;
   bit          sel = 1'b0;

   int          req_cyc[$];
   logic [15:0] req_addr[$];

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] addr;
   } vec_t;
   vec_t map_tbl [9];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   perf_counter_poller #(.HAS_SGMII(1'b0), .POLL_INTERVAL(20), .TIMEOUT_CYCLES(8)) dut0 (
      .clk_mgmt(clk), .rst_mgmt(rst), .enable(en0), .snapshot_req(snap0),
      .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_valid(rd_valid), .rd_data(rd_data),
      .cache_rd_en(cache_rd_en), .cache_rd_idx(cache_rd_idx),
      .cache_rd_valid(crv0), .cache_rd_data(crd0), .cache_rd_stale(crs0),
      .sweep_done(done0), .sweep_count(scnt0), .timeout_count(tcnt0), .busy(busy0)
   );

   perf_counter_poller #(.HAS_SGMII(1'b1), .POLL_INTERVAL(20), .TIMEOUT_CYCLES(8)) dut1 (
      .clk_mgmt(clk), .rst_mgmt(rst), .enable(en1), .snapshot_req(snap1),
      .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_valid(rd_valid), .rd_data(rd_data),
      .cache_rd_en(cache_rd_en), .cache_rd_idx(cache_rd_idx),
      .cache_rd_valid(crv1), .cache_rd_data(crd1), .cache_rd_stale(crs1),
      .sweep_done(done1), .sweep_count(scnt1), .timeout_count(tcnt1), .busy(busy1)
   );

   // Readout-block model: answers each request after a configurable latency.
   initial begin : responder
      bit          pend;
      int          cnt;
      logic [15:0] paddr;
      logic [47:0] pdata;
      pend = 1'b0; cnt = 0; paddr = '0; pdata = '0;
      rd_valid = 1'b0; rd_data = '0;
      forever begin
         @(posedge clk); #1;
         rd_valid = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               rd_valid = 1'b1;
               rd_data  = pdata;
               pend     = 1'b0;
            end
         end
         if (sel ? rd_en1 : rd_en0) begin
            paddr = sel ? rd_addr1 : rd_addr0;
            req_cyc.push_back(cyc);
            req_addr.push_back(paddr);
            pdata = {tag, 24'h000000, paddr};
            cnt   = lat;
            pend  = 1'b1;
            if (paddr == silent_addr) begin
               pend = late_en;
               cnt  = 9;
            end
            if (exact_en && paddr == 16'h1181) begin
               cnt   = 8;
               pdata = 48'h123456789ABC;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_done(input bit s, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (s ? done1 : done0) begin
            at = cyc;
            break;
         end
      end
      chk("sweep_done_seen", 64'(at >= 0), 64'd1);
   endtask

   task automatic wait_reqs(input int n);
      for (int i = 0; i < 300 && req_cyc.size() < n; i++) step(1);
      chk("requests_seen", 64'(req_cyc.size() >= n), 64'd1);
   endtask

   task automatic cache_read(input bit s, input logic [3:0] idx,
                             output logic [47:0] d, output logic st);
      cache_rd_en  = 1'b1;
      cache_rd_idx = idx;
      step(1);
      cache_rd_en = 1'b0;
      chk("cache_rd_valid", 64'(s ? crv1 : crv0), 64'd1);
      d  = s ? crd1 : crd0;
      st = s ? crs1 : crs0;
      step(1);
      chk("cache_rd_valid_once", 64'(s ? crv1 : crv0), 64'd0);
   endtask

   initial begin : main
      int          s1, s2, s3, s4, s5, s6, s7, rel, base;
      logic [47:0] d;
      logic        st;

      map_tbl[0] = '{4'd0, 16'h1000};
      map_tbl[1] = '{4'd1, 16'h1001};
      map_tbl[2] = '{4'd2, 16'h1180};
      map_tbl[3] = '{4'd3, 16'h1181};
      map_tbl[4] = '{4'd4, 16'h1182};
      map_tbl[5] = '{4'd5, 16'h0000};
      map_tbl[6] = '{4'd6, 16'h0001};
      map_tbl[7] = '{4'd7, 16'h0002};
      map_tbl[8] = '{4'd8, 16'h0003};

      rst = 1'b1; en0 = 1'b0; en1 = 1'b0; snap0 = 1'b0; snap1 = 1'b0;
      cache_rd_en = 1'b0; cache_rd_idx = '0;
      step(3);

      chk("reset_rd_en", 64'(rd_en0), 64'd0);
      chk("reset_rd_addr", 64'(rd_addr0), 64'd0);
      chk("reset_cache_rd_valid", 64'(crv0), 64'd0);
      chk("reset_cache_rd_data", 64'(crd0), 64'd0);
      chk("reset_cache_rd_stale", 64'(crs0), 64'd0);
      chk("reset_sweep_done", 64'(done0), 64'd0);
      chk("reset_sweep_count", 64'(scnt0), 64'd0);
      chk("reset_timeout_count", 64'(tcnt0), 64'd0);
      chk("reset_busy", 64'(busy0), 64'd0);

      // Sweep 1: fixed latency 5, five registers.
      en0 = 1'b1; rst = 1'b0; rel = cyc;
      wait_done(1'b0, 200, s1);
      tag = 8'h02; silent_addr = 16'h1181; late_en = 1'b1;
      chk("first_rd_en_latency", 64'(req_cyc[0] - rel), 64'd2);
      chk("sweep1_requests", 64'(req_addr.size()), 64'd5);
      chk("sweep1_done_timing", 64'(s1 - req_cyc[4]), 64'd6);
      chk("sweep1_count", 64'(scnt0), 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("sweep1_addr[%0d]", i), 64'(req_addr[i]), 64'(map_tbl[i].addr));
         if (i > 0) chk($sformatf("sweep1_spacing[%0d]", i), 64'(req_cyc[i] - req_cyc[i-1]), 64'd7);
         cache_read(1'b0, map_tbl[i].idx, d, st);
         chk($sformatf("sweep1_data[%0d]", i), 64'(d), 64'({8'h01, 24'h000000, map_tbl[i].addr}));
         chk($sformatf("sweep1_stale[%0d]", i), 64'(st), 64'd0);
      end
      cache_read(1'b0, 4'd7, d, st);
      chk("oob_data_idx7", 64'(d), 64'd0);
      chk("oob_stale_idx7", 64'(st), 64'd1);

      // Sweep 2: 0x1181 silent, late response one cycle after the window.
      wait_done(1'b0, 200, s2);
      silent_addr = 16'hFFFF; late_en = 1'b0; exact_en = 1'b1; tag = 8'h03;
      chk("interval_gap", 64'(req_cyc[5] - s1), 64'd22);
      chk("timeout_spacing", 64'(req_cyc[9] - req_cyc[8]), 64'd10);
      chk("timeout_count_1", 64'(tcnt0), 64'd1);
      chk("sweep2_count", 64'(scnt0), 64'd2);
      cache_read(1'b0, 4'd3, d, st);
      chk("timeout_keeps_data", 64'(d), 64'h0100_0000_1181);
      chk("timeout_stale", 64'(st), 64'd1);
      cache_read(1'b0, 4'd4, d, st);
      chk("after_timeout_data", 64'(d), 64'h0200_0000_1182);

      // Sweep 3: response on the last cycle of the window.
      wait_done(1'b0, 200, s3);
      exact_en = 1'b0; tag = 8'h04;
      chk("edge_spacing", 64'(req_cyc[14] - req_cyc[13]), 64'd10);
      chk("edge_timeout_count", 64'(tcnt0), 64'd1);
      cache_read(1'b0, 4'd3, d, st);
      chk("edge_data", 64'(d), 64'h1234_5678_9ABC);
      chk("edge_stale", 64'(st), 64'd0);

      // Sweep 4 with two snapshot pulses -> exactly one extra sweep.
      wait_reqs(17);
      snap0 = 1'b1; step(1); snap0 = 1'b0;
      step(3);
      snap0 = 1'b1; step(1); snap0 = 1'b0;
      wait_done(1'b0, 200, s4);
      wait_done(1'b0, 200, s5);
      chk("snapshot_restart", 64'(req_cyc[20] - s4), 64'd2);
      step(21);
      chk("snapshot_merged", 64'(req_cyc.size()), 64'd25);
      step(3);
      chk("interval_after_snapshot", 64'(req_cyc[25] - s5), 64'd22);

      // Reset during WAIT of idx 0; the outstanding response lands in IDLE.
      rst = 1'b1;
      step(1);
      chk("midreset_busy", 64'(busy0), 64'd0);
      chk("midreset_rd_en", 64'(rd_en0), 64'd0);
      chk("midreset_sweep_count", 64'(scnt0), 64'd0);
      chk("midreset_timeout_count", 64'(tcnt0), 64'd0);
      chk("midreset_sweep_done", 64'(done0), 64'd0);
      step(2);
      rst = 1'b0; rel = cyc; tag = 8'h06; base = req_cyc.size();
      for (int i = 0; i < 5; i++) begin
         cache_read(1'b0, 4'(i), d, st);
         chk($sformatf("postreset_data[%0d]", i), 64'(d), 64'd0);
         chk($sformatf("postreset_stale[%0d]", i), 64'(st), 64'd1);
      end
      wait_done(1'b0, 200, s6);
      en0 = 1'b0;
      chk("postreset_first_latency", 64'(req_cyc[base] - rel), 64'd2);
      chk("postreset_first_addr", 64'(req_addr[base]), 64'h1000);
      chk("postreset_sweep_count", 64'(scnt0), 64'd1);
      cache_read(1'b0, 4'd0, d, st);
      chk("postreset_refresh", 64'(d), 64'h0600_0000_1000);

      // SGMII instance: nine registers, enable dropped mid-sweep.
      sel = 1'b1; tag = 8'h07; base = req_cyc.size();
      en1 = 1'b1;
      wait_reqs(base + 3);
      en1 = 1'b0;
      wait_done(1'b1, 300, s7);
      chk("sgmii_requests", 64'(req_cyc.size() - base), 64'd9);
      chk("sgmii_sweep_count", 64'(scnt1), 64'd1);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("sgmii_addr[%0d]", i), 64'(req_addr[base+i]), 64'(map_tbl[i].addr));
         if (i > 0) chk($sformatf("sgmii_spacing[%0d]", i), 64'(req_cyc[base+i] - req_cyc[base+i-1]), 64'd7);
         cache_read(1'b1, map_tbl[i].idx, d, st);
         chk($sformatf("sgmii_data[%0d]", i), 64'(d), 64'({8'h07, 24'h000000, map_tbl[i].addr}));
         chk($sformatf("sgmii_stale[%0d]", i), 64'(st), 64'd0);
      end
      cache_read(1'b1, 4'd12, d, st);
      chk("oob_data_idx12", 64'(d), 64'd0);
      chk("oob_stale_idx12", 64'(st), 64'd1);
      step(30);
      chk("disabled_no_new_sweep", 64'(req_cyc.size() - base), 64'd9);
      chk("disabled_idle", 64'(busy1), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
